clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Programmable integer clock divider for the UART/system clocking path.
- Generates a divided clock-like signal `div_clk` and a one-cycle `div_tick` strobe, both derived from a single fast clock.
- The division ratio is a run-time input of parametrised width and supports both even and odd values.
- The ratio updates glitch-free at period boundaries, and a built-in bypass mode covers ratios below 2.

Parameters:
- RATIO_WIDTH, 8, width of `div_ratio`, the internal counter and the latched ratio; max ratio is 2^RATIO_WIDTH-1.
- PRESCALE_WIDTH, 6, width of the `prescale` input; only present with PRESCALE_DECODE_EN.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- clk_en  input  1  divider enable; when low, all state freezes.
- div_ratio  input  RATIO_WIDTH  requested division ratio N, sampled only at period boundaries.
- div_clk  output  1  divided clock, registered; high floor(N/2) cycles, low ceil(N/2) cycles.
- div_tick  output  1  registered one-cycle pulse marking the start of each divided period.

Behaviour:
- Internal state:
  - `cnt_q` [RATIO_WIDTH-1:0]
  - `ratio_q` [RATIO_WIDTH-1:0]
- Reset (rst=1 at a clk edge):
  - `cnt_q` <= 0, `div_clk` <= 0, `div_tick` <= 0.
  - `ratio_q` <= the effective ratio present on that edge.
  - rst has priority over clk_en and over any in-progress period; a reset mid-period aborts it with no partial pulse.
- clk_en=0 (not in reset):
  - `cnt_q`, `ratio_q` and `div_clk` hold.
  - `div_tick` <= 0.
- Divide mode (clk_en=1, `ratio_q` >= 2), evaluated in this priority order:
  - `cnt_q` == `ratio_q`-1: `cnt_q` <= 0, `div_clk` <= 1, `div_tick` <= 1, `ratio_q` <= effective ratio (new ratio takes effect from this period).
  - Else if `cnt_q` == floor(`ratio_q`/2)-1: `cnt_q` <= `cnt_q`+1, `div_clk` <= 0, `div_tick` <= 0.
  - Else: `cnt_q` <= `cnt_q`+1, `div_tick` <= 0, `div_clk` holds.
  - Resulting period is exactly `ratio_q` enabled cycles; `div_tick` is high in the first cycle of each high phase.
- Bypass mode (clk_en=1, `ratio_q` < 2, i.e. 0 or 1):
  - `div_tick` <= 1 every enabled cycle.
  - `div_clk` <= 0.
  - `cnt_q` <= 0.
  - `ratio_q` <= effective ratio every enabled cycle, so leaving bypass takes effect on the next edge.
- First output after reset:
  - Divide mode: first `div_tick`/`div_clk` rise occurs N enabled cycles after reset release.
  - Bypass mode: first `div_tick` on the first enabled edge after reset release.
- Ratio change mid-period: ignored until the wrap edge; no shortened or stretched phases.
- Counter never exceeds `ratio_q`-1. Ratio 2^RATIO_WIDTH-1 wraps correctly with no overflow bit.
- Effective ratio is `div_ratio` unless overridden by the optional feature.

Optional Feature:
- Macro: PRESCALE_DECODE_EN.
- Defined:
  - Adds input `prescale` [PRESCALE_WIDTH-1:0] and input `prescale_sel` [1].
  - When `prescale_sel`=1, effective ratio = decode of `prescale`, zero-extended to RATIO_WIDTH: 32->1, 16->2, 8->4, 4->8, any other value->1.
  - When `prescale_sel`=0, effective ratio = `div_ratio`.
  - Decode is combinational and sampled under the same boundary rules as `div_ratio`.
- Undefined: ports absent; effective ratio = `div_ratio`; no decode logic.

Test Plan:
- Even ratio: rst 1 cycle, `div_ratio`=4, clk_en=1 -> first `div_tick` on the 4th edge after release; then `div_clk` 1,1,0,0 repeating; `div_tick` every 4 cycles.
- Odd ratio with mid-period change: `div_ratio`=5 -> `div_clk` pattern 1,1,0,0,0. Change to 3 at `cnt_q`=2 -> current period completes at 5 cycles; next period 1,0,0.
- Enable gating: ratio 4, drop clk_en for 3 cycles at `cnt_q`=1 -> `div_clk` and `cnt_q` held, `div_tick`=0 while low; period stretches to 7 clk cycles.
- Bypass: `div_ratio`=1, then 0 -> `div_tick`=1 every enabled cycle, `div_clk`=0. Switch to 6 -> first `div_tick` 6 cycles after the switch edge.
- Reset mid-operation: ratio 8, assert rst at `cnt_q`=5 -> next edge `cnt_q`=0, `div_clk`=0, `div_tick`=0; no extra pulse; restart gives a full 8-cycle period.
- PRESCALE_DECODE_EN: `prescale_sel`=1, sweep `prescale`=32,16,8,4,7 -> periods 1 (bypass), 2, 4, 8, 1. With `prescale_sel`=0 and `div_ratio`=3 -> period 3.

Source files
------------

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog
// Brief    : Programmable integer clock divider. Produces a registered divided
//            clock and a start-of-period tick. Odd, even and bypass (<2) ratios
//            are supported, and ratio changes take effect at period boundaries.
//            Optional macro PRESCALE_DECODE_EN adds a power-of-two prescale
//            decode that can override div_ratio.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
  parameter int RATIO_WIDTH = 8
`ifdef PRESCALE_DECODE_EN
  ,
  parameter int PRESCALE_WIDTH = 6
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic [RATIO_WIDTH-1:0]    div_ratio,
`ifdef PRESCALE_DECODE_EN
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      prescale_sel,
`endif
  output logic                      div_clk,
  output logic                      div_tick
);

  logic [RATIO_WIDTH-1:0] cnt_q,   cnt_d;
  logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
  logic                   div_clk_q, div_clk_d;
  logic                   div_tick_q, div_tick_d;
  logic [RATIO_WIDTH-1:0] eff_ratio;
  logic [RATIO_WIDTH-1:0] last_cnt;
  logic [RATIO_WIDTH-1:0] fall_cnt;
  logic                   bypass;

`ifdef PRESCALE_DECODE_EN
  logic [RATIO_WIDTH-1:0] decoded_ratio;

  always_comb begin
    decoded_ratio = RATIO_WIDTH'(1);
    case (prescale)
      PRESCALE_WIDTH'(32): decoded_ratio = RATIO_WIDTH'(1);
      PRESCALE_WIDTH'(16): decoded_ratio = RATIO_WIDTH'(2);
      PRESCALE_WIDTH'(8):  decoded_ratio = RATIO_WIDTH'(4);
      PRESCALE_WIDTH'(4):  decoded_ratio = RATIO_WIDTH'(8);
      default:             decoded_ratio = RATIO_WIDTH'(1);
    endcase
  end

  assign eff_ratio = prescale_sel ? decoded_ratio : div_ratio;
`else
  assign eff_ratio = div_ratio;
`endif

  // Ratios 0 and 1 cannot form a two-phase clock, so they run as bypass.
  assign bypass   = (ratio_q[RATIO_WIDTH-1:1] == '0);
  assign last_cnt = ratio_q - RATIO_WIDTH'(1);
  assign fall_cnt = (ratio_q >> 1) - RATIO_WIDTH'(1);

  always_comb begin
    cnt_d      = cnt_q;
    ratio_d    = ratio_q;
    div_clk_d  = div_clk_q;
    div_tick_d = 1'b0;
    if (clk_en) begin
      if (bypass) begin
        cnt_d      = '0;
        div_clk_d  = 1'b0;
        div_tick_d = 1'b1;
        ratio_d    = eff_ratio;
      end else if (cnt_q == last_cnt) begin
        // Wrap is checked first so the counter can never run past ratio-1.
        cnt_d      = '0;
        div_clk_d  = 1'b1;
        div_tick_d = 1'b1;
        ratio_d    = eff_ratio;
      end else if (cnt_q == fall_cnt) begin
        cnt_d      = cnt_q + RATIO_WIDTH'(1);
        div_clk_d  = 1'b0;
      end else begin
        cnt_d      = cnt_q + RATIO_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ratio_q    <= eff_ratio;
      div_clk_q  <= 1'b0;
      div_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      div_clk_q  <= div_clk_d;
      div_tick_q <= div_tick_d;
    end
  end

  assign div_clk  = div_clk_q;
  assign div_tick = div_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_prog
// Brief    : Directed, table-driven bench for clk_div_prog; expected outputs are
//            hand-computed per clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

  localparam int RW = 8;

  typedef struct {
    string   name;
    logic    rst;
    logic    en;
    logic [RW-1:0] ratio;
    logic    exp_clk;
    logic    exp_tick;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [RW-1:0] div_ratio;
  logic          div_clk;
  logic          div_tick;
`ifdef PRESCALE_DECODE_EN
  logic [5:0]    prescale;
  logic          prescale_sel;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  clk_div_prog #(.RATIO_WIDTH(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .div_ratio    (div_ratio),
`ifdef PRESCALE_DECODE_EN
    .prescale     (prescale),
    .prescale_sel (prescale_sel),
`endif
    .div_clk      (div_clk),
    .div_tick     (div_tick)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [RW-1:0] ra);
    @(negedge clk);
    rst = r; clk_en = e; div_ratio = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic r, input logic e,
                     input int ra, input logic c, input logic t);
    vq.push_back('{nm, r, e, RW'(ra), c, t});
  endtask

  int hi_cnt;
  int tk_cnt;
  int wait_n;

  initial begin
    rst = 1'b1; clk_en = 1'b0; div_ratio = '0;
`ifdef PRESCALE_DECODE_EN
    prescale = '0; prescale_sel = 1'b0;
`endif

    // Even ratio 4: first tick on 4th edge, then 1,1,0,0.
    add("even_rst", 1, 1, 4, 0, 0);
    add("even_e1",  0, 1, 4, 0, 0);
    add("even_e2",  0, 1, 4, 0, 0);
    add("even_e3",  0, 1, 4, 0, 0);
    add("even_e4",  0, 1, 4, 1, 1);
    add("even_e5",  0, 1, 4, 1, 0);
    add("even_e6",  0, 1, 4, 0, 0);
    add("even_e7",  0, 1, 4, 0, 0);
    add("even_e8",  0, 1, 4, 1, 1);
    // Odd ratio 5, change to 3 while cnt=2: current period still 5 long.
    add("odd_rst",  1, 1, 5, 0, 0);
    add("odd_e1",   0, 1, 5, 0, 0);
    add("odd_e2",   0, 1, 5, 0, 0);
    add("odd_e3",   0, 1, 5, 0, 0);
    add("odd_e4",   0, 1, 5, 0, 0);
    add("odd_e5",   0, 1, 5, 1, 1);
    add("odd_e6",   0, 1, 5, 1, 0);
    add("odd_e7",   0, 1, 5, 0, 0);
    add("odd_chg8", 0, 1, 3, 0, 0);
    add("odd_chg9", 0, 1, 3, 0, 0);
    add("odd_wrap", 0, 1, 3, 1, 1);
    add("r3_e1",    0, 1, 3, 0, 0);
    add("r3_e2",    0, 1, 3, 0, 0);
    add("r3_wrap",  0, 1, 3, 1, 1);
    // Enable gating at cnt=1 in the high phase: period stretches to 7.
    add("en_rst",   1, 1, 4, 0, 0);
    add("en_e1",    0, 1, 4, 0, 0);
    add("en_e2",    0, 1, 4, 0, 0);
    add("en_e3",    0, 1, 4, 0, 0);
    add("en_e4",    0, 1, 4, 1, 1);
    add("en_e5",    0, 1, 4, 1, 0);
    add("en_off1",  0, 0, 4, 1, 0);
    add("en_off2",  0, 0, 4, 1, 0);
    add("en_off3",  0, 0, 4, 1, 0);
    add("en_on1",   0, 1, 4, 0, 0);
    add("en_on2",   0, 1, 4, 0, 0);
    add("en_wrap",  0, 1, 4, 1, 1);
    add("en_offtk", 0, 0, 4, 1, 0);
    // Bypass 1 then 0, then switch to 6.
    add("byp_rst",  1, 1, 1, 0, 0);
    add("byp_r1",   0, 1, 1, 0, 1);
    add("byp_r0a",  0, 1, 0, 0, 1);
    add("byp_r0b",  0, 1, 0, 0, 1);
    add("byp_off",  0, 0, 0, 0, 0);
    add("byp_sw6",  0, 1, 6, 0, 1);
    add("r6_e1",    0, 1, 6, 0, 0);
    add("r6_e2",    0, 1, 6, 0, 0);
    add("r6_e3",    0, 1, 6, 0, 0);
    add("r6_e4",    0, 1, 6, 0, 0);
    add("r6_e5",    0, 1, 6, 0, 0);
    add("r6_wrap",  0, 1, 6, 1, 1);
    add("r6_h1",    0, 1, 6, 1, 0);
    add("r6_h2",    0, 1, 6, 1, 0);
    add("r6_fall",  0, 1, 6, 0, 0);
    // Ratio 2: alternating.
    add("r2_rst",   1, 1, 2, 0, 0);
    add("r2_e1",    0, 1, 2, 0, 0);
    add("r2_e2",    0, 1, 2, 1, 1);
    add("r2_e3",    0, 1, 2, 0, 0);
    add("r2_e4",    0, 1, 2, 1, 1);
    // Ratio 8, reset at cnt=5, then a full 8-cycle restart.
    add("r8_rst",   1, 1, 8, 0, 0);
    for (int i = 1; i <= 7; i++) add("r8_lo", 0, 1, 8, 0, 0);
    add("r8_wrap",  0, 1, 8, 1, 1);
    add("r8_h1",    0, 1, 8, 1, 0);
    add("r8_h2",    0, 1, 8, 1, 0);
    add("r8_h3",    0, 1, 8, 1, 0);
    add("r8_fall",  0, 1, 8, 0, 0);
    add("r8_c5",    0, 1, 8, 0, 0);
    add("r8_midrst",1, 1, 8, 0, 0);
    for (int i = 1; i <= 7; i++) add("r8_re_lo", 0, 1, 8, 0, 0);
    add("r8_re_wrap",0, 1, 8, 1, 1);
    add("r8_h",     0, 1, 8, 1, 0);
    add("rst_noen", 1, 0, 8, 0, 0);
    add("after_rst",0, 1, 8, 0, 0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].en, vq[i].ratio);
      check({vq[i].name, ".div_clk"},  int'(div_clk),  int'(vq[i].exp_clk));
      check({vq[i].name, ".div_tick"}, int'(div_tick), int'(vq[i].exp_tick));
    end

    // Maximum ratio 255: first tick on edge 255, then 127 high / 1 tick per period.
    step(1'b1, 1'b1, RW'(255));
    tk_cnt = 0;
    for (int i = 1; i < 255; i++) begin
      step(1'b0, 1'b1, RW'(255));
      if (div_tick) tk_cnt++;
    end
    check("max_no_early_tick", tk_cnt, 0);
    step(1'b0, 1'b1, RW'(255));
    check("max_first_tick", int'(div_tick), 1);
    hi_cnt = 0; tk_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      step(1'b0, 1'b1, RW'(255));
      if (div_clk) hi_cnt++;
      if (div_tick) tk_cnt++;
    end
    check("max_high_cycles", hi_cnt, 128 - 1);
    check("max_ticks_per_period", tk_cnt, 1);
    check("max_end_tick", int'(div_tick), 1);

`ifdef PRESCALE_DECODE_EN
    begin
      int ps_tab[5]  = '{32, 16, 8, 4, 7};
      int per_tab[5] = '{1, 2, 4, 8, 1};
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        prescale_sel = (k < 5);
        prescale     = (k < 5) ? 6'(ps_tab[k]) : 6'd0;
        step(1'b1, 1'b1, RW'(3));
        wait_n = 0;
        do begin
          step(1'b0, 1'b1, RW'(3));
          wait_n++;
        end while (!div_tick && wait_n < 20);
        check("prescale_first_tick", wait_n, (k < 5) ? per_tab[k] : 3);
        wait_n = 0;
        do begin
          step(1'b0, 1'b1, RW'(3));
          wait_n++;
        end while (!div_tick && wait_n < 20);
        check("prescale_period", wait_n, (k < 5) ? per_tab[k] : 3);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
